// File: rtl/node_sched_pkg.sv
// Shared types for the per-node tik scheduler: sweep state encoding and default widths.
package node_sched_pkg;

  localparam int NNW_DEF = 12;
  localparam int NNW_CNT = NNW_DEF + 1;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SWEEP,
    FLUSH,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-latency shift register; every stage clears on reset.
module sched_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < D; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[D-1];

endmodule

// File: rtl/node_tik_sched.sv
// Per-node time-step scheduler: on tik, drain the spike path, then sweep neurons
// 0..n_lat-1 through sd read-clear and soma update, stalling on spk_out backpressure.
module node_tik_sched
  import node_sched_pkg::*;
#(
  parameter int NNW  = NNW_DEF,
  parameter int PIPE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tik,
  input  logic           enable,
  input  logic [NNW:0]   neu_num,
  input  logic           axon_busy,
  input  logic           spk_in_empty,
  input  logic           spk_out_full,
  output logic           sched_hold,
  output logic           sd_vld,
  output logic [NNW-1:0] sd_vm_addr,
  output logic           sd_clear,
  output logic           soma_vld,
  output logic [NNW-1:0] soma_vm_addr,
  output logic           sched_busy,
  output logic           done,
  output logic           tik_overrun
);

  localparam int FCW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(PIPE - 1);
  localparam logic [NNW:0]   N_ONE  = {{NNW{1'b0}}, 1'b1};

  sched_state_t   state, state_nxt;
  logic [NNW-1:0] addr;
  logic [NNW:0]   n_lat;
  logic           pending;
  logic [FCW-1:0] fcnt;
  logic           ovr_q;

  logic tik_eff, drain_ok, issue, last_issue, flush_end;
  logic [NNW:0] soma_bus;

  assign tik_eff    = tik & enable;
  assign drain_ok   = ~axon_busy & spk_in_empty;
  assign issue      = (state == SWEEP) & ~spk_out_full;
  assign last_issue = issue & ({1'b0, addr} == (n_lat - N_ONE));
  assign flush_end  = (state == FLUSH) & (fcnt == F_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sched_hold = 1'b0;
    sched_busy = 1'b0;
    sd_vld     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (tik_eff | pending) state_nxt = DRAIN;
      end
      DRAIN: begin
        sched_hold = 1'b1;
        sched_busy = 1'b1;
        if (drain_ok) state_nxt = (n_lat == '0) ? FLUSH : SWEEP;
      end
      SWEEP: begin
        sched_hold = 1'b1;
        sched_busy = 1'b1;
        sd_vld     = issue;
        if (last_issue) state_nxt = FLUSH;
      end
      FLUSH: begin
        sched_hold = 1'b1;
        sched_busy = 1'b1;
        if (flush_end) state_nxt = DONE;
      end
      DONE: begin
        sched_hold = 1'b1;
        sched_busy = 1'b1;
        done       = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A tik landing on the same IDLE cycle that serves a pending request is
  // deferred into pending again rather than merged into the current sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      n_lat   <= '0;
      pending <= 1'b0;
      fcnt    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (state == IDLE) begin
        if (tik_eff | pending) begin
          n_lat <= neu_num;
          if (tik_eff & pending) ovr_q <= 1'b1;
          else                   pending <= 1'b0;
        end
      end else if (tik_eff) begin
        pending <= 1'b1;
        ovr_q   <= 1'b1;
      end
      if (issue) addr <= last_issue ? '0 : addr + 1'b1;
      if (state == FLUSH) fcnt <= fcnt + 1'b1;
      else                fcnt <= '0;
    end
  end

  assign sd_vm_addr  = addr;
  assign sd_clear    = sd_vld;
  assign tik_overrun = ovr_q;

  sched_delay_line #(
    .W(NNW + 1),
    .D(PIPE)
  ) u_soma_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({sd_vld, sd_vm_addr}),
    .dout (soma_bus)
  );

  assign soma_vld     = soma_bus[NNW];
  assign soma_vm_addr = soma_bus[NNW-1:0];

endmodule

// File: doc/node_tik_sched.md
Name: node_tik_sched

Overview:
- Per-node time-step scheduler. Sequences the neuron-update sweep that follows each tik.
- On tik it first freezes spike intake and waits for the axon and spk_in path to drain.
- It then walks neuron addresses 0..neu_num-1 through the sd accumulator read-clear and the soma update, one address per cycle, stalling on spk_out backpressure.
- It sits between config_top (neu_num, enable), the axon/spk_in pair (busy/empty) and the sd/soma address ports.

Parameters:
- NNW, 12, neuron address width.
- PIPE, 1, cycles from sd read to soma_vm input (sd read latency); must be ≥1.

Ports:
- clk  in  1  node clock.
- rst  in  1  asynchronous, active-high reset.
- tik  in  1  time-step pulse, one cycle.
- enable  in  1  scheduler enable from config.
- neu_num  in  NNW+1  neurons to sweep, 0..2^NNW.
- axon_busy  in  1  axon still expanding spikes.
- spk_in_empty  in  1  spk_in holds no undelivered spike flits.
- spk_out_full  in  1  spk_out FIFO almost-full; asserted with ≥PIPE+1 entries of slack.
- sched_hold  out  1  spk_in must not issue new axon spikes.
- sd_vld  out  1  sd read-and-clear strobe.
- sd_vm_addr  out  NNW  sd address.
- sd_clear  out  1  clear accumulator at sd_vm_addr (equals sd_vld).
- soma_vld  out  1  soma update strobe.
- soma_vm_addr  out  NNW  soma address.
- sched_busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at sweep end.
- tik_overrun  out  1  one-cycle pulse when a tik is dropped or deferred.

Behaviour:
- Reset: all outputs 0, state IDLE, address counter 0, pending-tik flag 0. Asynchronous assert; takes effect mid-sweep without completing it.
- States: IDLE → DRAIN → SWEEP → FLUSH → DONE → IDLE. All registered; outputs decode from state and registers.
- IDLE:
  - Leaves on (tik & enable) or pending.
  - Clears pending and latches neu_num into n_lat.
  - tik while !enable is ignored, with no overrun.
- DRAIN:
  - sched_hold=1.
  - When axon_busy==0 & spk_in_empty==1 in a cycle, goes to SWEEP next edge, or to FLUSH if n_lat==0.
  - No timeout.
- SWEEP:
  - sched_hold=1. Each cycle with !spk_out_full: sd_vld=sd_clear=1, sd_vm_addr=addr, addr++.
  - When full: sd_vld=0 and addr holds.
  - After issuing addr==n_lat-1: addr←0, go to FLUSH.
  - n_lat==2^NNW sweeps the full space; addr wraps to 0 with no overflow flag.
- FLUSH: holds PIPE cycles so the soma tail drains; sched_hold=1.
- DONE: done=1 for one cycle; sched_hold drops on IDLE entry.
- soma_vld/soma_vm_addr: sd_vld/sd_vm_addr delayed exactly PIPE cycles; in-flight entries are not stalled by spk_out_full.
- tik while state ≠ IDLE:
  - If pending==0: set pending, tik_overrun=1 next cycle.
  - If pending==1: tik dropped, tik_overrun=1.
- tik in same cycle as DONE counts as a not-IDLE tik (pending).
- Deasserting enable mid-sweep: current sweep completes; pending still served.
- neu_num changes mid-sweep: ignored (n_lat used).
- Latency, tik at edge 0 with drain satisfied and no stall: first sd_vld cycle 2, done at cycle 2+n_lat+PIPE.

Decomposition:
- Package node_sched_pkg holds:
  - State enum: IDLE, DRAIN, SWEEP, FLUSH, DONE.
  - Width localparams NNW and NNW+1.
- One sub-module, sched_delay_line (parameterised width/depth shift register, reset to 0), produces soma_vld/soma_vm_addr from sd_vld/sd_vm_addr.

Test Plan:
- neu_num=4, PIPE=1, enable=1, tik cycle 0 → sd_vld cycles 2-5 addr 0,1,2,3; soma_vld cycles 3-6 same addrs; done cycle 7; sched_hold 1 cycles 1-7.
- Same, spk_out_full high cycles 3-4 → sd addrs 0@2, 1@5, 2@6, 3@7; done cycle 9; soma never shows duplicates or gaps.
- axon_busy high cycles 0-5 after tik → DRAIN until cycle 6; first sd_vld cycle 7, no sd_vld earlier.
- neu_num=0, tik cycle 0 → no sd_vld/soma_vld; done cycle 3.
- neu_num=4, tik cycle 0 and cycle 3 → tik_overrun cycle 4; second sweep starts after done (addr 0 again); third tik during first sweep → second tik_overrun, only two sweeps total.
- rst asserted cycle 4 of a sweep → all outputs 0 immediately; pending cleared; next tik sweeps from addr 0.
